// File: rtl/mdu_seq_pkg.sv
// Purpose : shared op encodings, FSM state type and op decode helpers for the mdu_seq multiply/divide unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Purpose : conditional two's-complement negation; gives |x| on operands (neg_i = sign) and sign-corrects results.
// Latency : combinational.
// Backpr. : none.
// Ports   : val_i value in, neg_i negate request, val_o result.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mdu_seq.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Latency : start accepted in IDLE -> busy for W CALC + 1 FIX cycles -> done pulse at cycle W+2.
// Backpr. : start is only accepted in IDLE and never queued; the pipeline stalls on busy_o.
// Ports   : start_i/op_i/a_i/b_i request; wr_hi_i/wr_lo_i/wdata_i MTHI/MTLO;
//           busy_o, done_o, div0_o status; hi_o/lo_o HI/LO registers.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         wr_hi_i,
    input  logic         wr_lo_i,
    input  logic [W-1:0] wdata_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         div0_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CW = $clog2(W) + 1;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic             is_div_q, neg_res_q, neg_rem_q;
    logic             busy_q, done_q, div0_q;
    logic [W-1:0]     b_q, a_raw_q, hi_q, lo_q;
    logic [2*W-1:0]   acc_q, acc_d;

    // Operand magnitudes (raw value for unsigned ops).
    logic         sgn_op;
    logic [W-1:0] a_mag, b_mag;
    assign sgn_op = op_is_signed(op_i);

    mdu_signfix #(.W(W)) u_abs_a (.val_i(a_i), .neg_i(sgn_op & a_i[W-1]), .val_o(a_mag));
    mdu_signfix #(.W(W)) u_abs_b (.val_i(b_i), .neg_i(sgn_op & b_i[W-1]), .val_o(b_mag));

    // Shared (W+1)-bit adder. Multiply: hi half + multiplicand. Divide: the
    // left-shifted partial remainder minus divisor via ~b + 1; the extra carry
    // bit set means no borrow, i.e. the subtraction succeeded.
    logic [W:0]   rem_sh, add_x, add_y;
    logic [W+1:0] add_sum;
    assign rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};

    always_comb begin
        add_x   = is_div_q ? rem_sh : {1'b0, acc_q[2*W-1:W]};
        add_y   = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
        add_sum = {1'b0, add_x} + {1'b0, add_y} + (W+2)'(is_div_q);
    end

    // One radix-2 step. Multiply shifts right, bringing the adder carry in at
    // the top; divide shifts left, pushing the quotient bit into the bottom.
    always_comb begin
        acc_d = acc_q;
        if (is_div_q) begin
            if (add_sum[W+1]) acc_d = {add_sum[W-1:0], acc_q[W-2:0], 1'b1};
            else              acc_d = {rem_sh[W-1:0],  acc_q[W-2:0], 1'b0};
        end else begin
            if (acc_q[0]) acc_d = {add_sum[W:0], acc_q[W-1:1]};
            else          acc_d = {1'b0, acc_q[2*W-1:1]};
        end
    end

    // Output sign correction: whole product, or quotient/remainder separately.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    mdu_signfix #(.W(2*W)) u_fix_prod (.val_i(acc_q),            .neg_i(neg_res_q), .val_o(prod_fix));
    mdu_signfix #(.W(W))   u_fix_quo  (.val_i(acc_q[W-1:0]),     .neg_i(neg_res_q), .val_o(quo_fix));
    mdu_signfix #(.W(W))   u_fix_rem  (.val_i(acc_q[2*W-1:W]),   .neg_i(neg_rem_q), .val_o(rem_fix));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            b_q       <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_hi_i) hi_q <= wdata_i;
                    if (wr_lo_i) lo_q <= wdata_i;
                    if (start_i) begin
                        state_q   <= ST_CALC;
                        busy_q    <= 1'b1;
                        count_q   <= CW'(W);
                        is_div_q  <= op_is_div(op_i);
                        neg_res_q <= sgn_op & (a_i[W-1] ^ b_i[W-1]);
                        neg_rem_q <= sgn_op & a_i[W-1];
                        acc_q     <= {{W{1'b0}}, a_mag};
                        b_q       <= b_mag;
                        a_raw_q   <= a_i;
                        div0_q    <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (b_q == '0) begin
                        // Divide by zero: full latency taken, fixed result.
                        hi_q   <= a_raw_q;
                        lo_q   <= '1;
                        div0_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (wr_hi_i) hi_q <= wdata_i;
                    if (wr_lo_i) lo_q <= wdata_i;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign div0_o = div0_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // W=32 instance
    logic        start32, wr_hi32, wr_lo32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wdata32;
    logic        busy32, done32, div0_32;
    logic [31:0] hi32, lo32;
    // W=8 instance
    logic        start8, wr_hi8, wr_lo8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8;
    logic        busy8, done8, div0_8;
    logic [7:0]  hi8, lo8;

    mdu_seq #(.W(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
        .wr_hi_i(wr_hi32), .wr_lo_i(wr_lo32), .wdata_i(wdata32),
        .busy_o(busy32), .done_o(done32), .div0_o(div0_32), .hi_o(hi32), .lo_o(lo32)
    );

    mdu_seq #(.W(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
        .wr_hi_i(wr_hi8), .wr_lo_i(wr_lo8), .wdata_i(wdata8),
        .busy_o(busy8), .done_o(done8), .div0_o(div0_8), .hi_o(hi8), .lo_o(lo8)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Scoreboard monitors: pop an expectation whenever a done pulse appears.
    always @(negedge clk) begin
        if (rst_n && done32) begin
            if (q32.size() == 0) begin
                chk("done32_unexpected", {63'd0, done32}, 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("hi32", {32'd0, hi32}, {32'd0, e32.hi});
                chk("lo32", {32'd0, lo32}, {32'd0, e32.lo});
                chk("div0_32", {63'd0, div0_32}, {63'd0, e32.div0});
            end
        end
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", {63'd0, done8}, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("hi8", {56'd0, hi8}, {32'd0, e8.hi});
                chk("lo8", {56'd0, lo8}, {32'd0, e8.lo});
                chk("div0_8", {63'd0, div0_8}, {63'd0, e8.div0});
            end
        end
    end

    // Advance to 1 time unit after the n-th next rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eh, input logic [31:0] el, input logic ed);
        op32 = o; a32 = av; b32 = bv; start32 = 1'b1;
        q32.push_back('{hi: eh, lo: el, div0: ed});
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] eh, input logic [7:0] el, input logic ed);
        op8 = o; a8 = av; b8 = bv; start8 = 1'b1;
        q8.push_back('{hi: {24'd0, eh}, lo: {24'd0, el}, div0: ed});
    endtask

    // Wait (bounded) for done; k0 is the cycle index of the next falling edge
    // relative to the accepting cycle 0. Ends at the first IDLE cycle after DONE.
    task automatic wait_done(input bit w8, input int k0, input int exp_lat, input string nm);
        int  k;
        bit  seen;
        seen = 1'b0;
        for (k = k0; k < k0 + 60; k++) begin
            @(negedge clk);
            if (w8 ? done8 : done32) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, "_seen"}, {63'd0, seen}, 64'd1);
        if (seen) chk({nm, "_latency"}, 64'(k), 64'(exp_lat));
        tick(1);
    endtask

    task automatic op32_run(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] eh, input logic [31:0] el, input logic ed,
                            input string nm);
        issue32(o, av, bv, eh, el, ed);
        tick(1);
        start32 = 1'b0;
        wait_done(1'b0, 1, 34, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start32 = 0; wr_hi32 = 0; wr_lo32 = 0; op32 = 0; a32 = 0; b32 = 0; wdata32 = 0;
        start8 = 0;  wr_hi8 = 0;  wr_lo8 = 0;  op8 = 0;  a8 = 0;  b8 = 0;  wdata8 = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", {63'd0, busy32}, 64'd0);
        chk("rst_done", {63'd0, done32}, 64'd0);
        chk("rst_div0", {63'd0, div0_32}, 64'd0);
        chk("rst_hi", {32'd0, hi32}, 64'd0);
        chk("rst_lo", {32'd0, lo32}, 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // MULT -3*7 with cycle-accurate busy/done profile
        issue32(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        @(negedge clk);
        chk("t_busy_c0", {63'd0, busy32}, 64'd0);
        tick(1);
        start32 = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            chk($sformatf("t_busy_c%0d", c), {63'd0, busy32}, {63'd0, (c >= 1 && c <= 33)});
            chk($sformatf("t_done_c%0d", c), {63'd0, done32}, {63'd0, (c == 34)});
        end
        tick(1);

        op32_run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        op32_run(OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 1'b0, "divu_7_2");
        op32_run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        op32_run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
        op32_run(OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_by0");

        // MULT after divide-by-zero: div0 clears on acceptance
        issue32(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        tick(1);
        start32 = 1'b0;
        @(negedge clk);
        chk("div0_clear", {63'd0, div0_32}, 64'd0);
        wait_done(1'b0, 2, 34, "mult_2_3");

        // Ignored start/wr_hi/op/operand changes in cycle 5
        issue32(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        tick(1);
        start32 = 1'b0;
        tick(4);
        start32 = 1'b1; wr_hi32 = 1'b1; wdata32 = 32'hDEAD_BEEF;
        op32 = OP_MULT; a32 = 32'h1111_1111; b32 = 32'h2222_2222;
        tick(1);
        start32 = 1'b0; wr_hi32 = 1'b0;
        tick(4);
        @(negedge clk);
        chk("calc_hi_stable", {32'd0, hi32}, 64'd0);
        chk("calc_lo_stable", {32'd0, lo32}, 64'd6);
        chk("calc_busy", {63'd0, busy32}, 64'd1);
        wait_done(1'b0, 11, 34, "divu_junk");
        tick(40);

        // MTLO in IDLE
        wr_lo32 = 1'b1; wdata32 = 32'h0000_1234;
        @(negedge clk);
        chk("mtlo_before", {32'd0, lo32}, 64'd14);
        tick(1);
        wr_lo32 = 1'b0;
        @(negedge clk);
        chk("mtlo_after", {32'd0, lo32}, 64'h1234);
        tick(1);

        // Asynchronous reset in cycle 10 of a MULT
        issue32(OP_MULT, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        tick(1);
        start32 = 1'b0;
        tick(9);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy32}, 64'd0);
        chk("arst_done", {63'd0, done32}, 64'd0);
        chk("arst_div0", {63'd0, div0_32}, 64'd0);
        chk("arst_hi", {32'd0, hi32}, 64'd0);
        chk("arst_lo", {32'd0, lo32}, 64'd0);
        q32.delete();
        tick(2);
        rst_n = 1'b1;
        tick(40);

        // Fresh MULTU 3*4 with a same-cycle MTHI that the result later overwrites
        issue32(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'hC, 1'b0);
        wr_hi32 = 1'b1; wdata32 = 32'h0000_FFFF;
        tick(1);
        start32 = 1'b0; wr_hi32 = 1'b0;
        @(negedge clk);
        chk("mthi_with_start", {32'd0, hi32}, 64'hFFFF);
        wait_done(1'b0, 2, 34, "multu_3_4");

        // W=8 instance
        issue8(OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
        tick(1);
        start8 = 1'b0;
        wait_done(1'b1, 1, 10, "w8_mult");
        issue8(OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        tick(1);
        start8 = 1'b0;
        wait_done(1'b1, 1, 10, "w8_div_ovf");

        tick(5);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised, iterative multiply/divide unit that extends the datapath's combinational ALU with the four MIPS HI/LO operations: MULT, MULTU, DIV and DIVU. It performs radix-2 shift-add multiplication and restoring division over `W` cycles and holds the result in architectural HI/LO registers. It also services MTHI/MTLO writes. It sits beside the ALU in the execute stage; the pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `W`, 32, operand width; W ≥ 2; counter width is $clog2(W)+1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation; accepted only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b` in W: operands, captured on the accepting edge; `a` is the dividend, `b` the divisor.
- `wr_hi`, `wr_lo` in 1: MTHI/MTLO write enables.
- `wdata` in W: MTHI/MTLO data.
- `busy` out 1: operation in progress (CALC or FIX).
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `div0` out 1: the last completed divide had `b == 0`; valid while `done`=1.
- `hi`, `lo` out W: HI/LO registers.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE → CALC on `start`: latch `op`, the operand magnitudes (|x| for signed ops, raw value for unsigned ops), the result sign, the dividend sign, and `count = W`.
  - CALC: one iteration per cycle; `count` decrements; CALC → FIX when `count` reaches 1 at the edge.
  - FIX → DONE: apply the sign correction and write `hi`/`lo`.
  - DONE → IDLE unconditionally.
- Multiply: 2W-bit product; `hi` = upper W bits, `lo` = lower W bits. Signed ops negate the 2W-bit product when the operand signs differ.
- Divide: `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend.
- Signed most-negative ÷ −1: `lo` = most-negative value (wraps), `hi` = 0, `div0` = 0.
- Divide by zero, signed or unsigned:
  - Full latency is still taken.
  - `lo` = all ones, `hi` = `a` as captured, `div0` = 1.
- `div0` clears at the next accepted `start`.
- MTHI/MTLO:
  - `wr_hi` / `wr_lo` load `wdata` at the edge when the state is IDLE or DONE.
  - They are ignored in CALC and FIX.
  - A write in the same cycle as an accepted `start` takes effect; the operation's result later overwrites it.
- `start` in CALC, FIX or DONE is ignored; it is not queued.
- Operand changes after the accepting edge have no effect.

## Timing
- Reset (asynchronous, any state): state = IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, `div0` = 0, internal registers cleared. An in-flight operation is discarded.
- With `start` high in cycle 0 (state IDLE):
  - `busy` = 1 in cycles 1 … W+1 (W CALC cycles plus one FIX cycle).
  - `done` = 1 in cycle W+2 only.
  - `hi`/`lo` show the new result from cycle W+2.
- Back-to-back: the earliest next acceptance is cycle W+3 (IDLE), giving a throughput of one operation per W+3 cycles.
- `hi`/`lo` remain stable during CALC/FIX and keep their previous values until FIX completes.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`);
  - the state enum (IDLE/CALC/FIX/DONE).
- One sub-module, `mdu_signfix`: combinational, parametrised by width. It provides absolute value on the input side and conditional two's-complement negation on the output side. It is instantiated for the operands and for the 2W-bit result.
- Top-level `mdu_seq` holds the FSM, the counter, the shared 2W-bit accumulator/shift register, and a (W+1)-bit adder/subtractor used in both modes.

## Test plan
- MULT, W=32, `a`=FFFFFFFD, `b`=00000007, `start` in cycle 0 → `busy` in cycles 1–33, `done` in cycle 34; `hi`=FFFFFFFF, `lo`=FFFFFFEB.
- MULTU FFFFFFFF × FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001. Then DIVU 7/2 → `lo`=3, `hi`=1.
- DIV FFFFFFF9 / 00000002 (−7/2) → `lo`=FFFFFFFD, `hi`=FFFFFFFF. DIV 80000000 / FFFFFFFF → `lo`=80000000, `hi`=0, `div0`=0.
- DIVU 5/0 → `done` in cycle 34 with `div0`=1, `lo`=FFFFFFFF, `hi`=00000005. A following MULT clears `div0`.
- Ignored inputs during an operation:
  - `start`, `wr_hi` and `op` changes in cycle 5 → ignored; the result is unchanged.
  - `wr_lo` with `wdata`=1234 in IDLE → `lo`=1234 next cycle.
  - `rst_n` low in cycle 10 → all outputs 0 immediately and no `done`.
  - A fresh MULTU 3×4 afterwards → `lo`=C.
- Instance with W=8: MULT 80 × 80 → `done` in cycle 10, `hi`=40, `lo`=00. DIV 80/FF → `lo`=80, `hi`=00.
